// File: rtl/param_mux_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : param_mux_arb_if
// Description : Channel-side and consumer-side handshake bundle for
//               param_mux_arb (N_IN producers merged into one consumer).
// Revision    : 1.0 - initial release
// ============================================================================
interface param_mux_arb_if #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 8,
    parameter int SEL_W = 3
);
    logic [N_IN*WIDTH-1:0] in_data;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN-1:0]       in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_src;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_src, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/param_mux_arb.sv
`default_nettype none
// ============================================================================
// Module      : param_mux_arb
// Description : N-input valid/ready multiplexer with directed-select or
//               round-robin grant and a single registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module param_mux_arb #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 8,
    parameter int SEL_W = 3
) (
    input wire             clk,
    input wire             reset,
    param_mux_arb_if.slave bus
);

    localparam logic [SEL_W-1:0] c_last_init = SEL_W'(N_IN - 1);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_src;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_last;

    logic             w_space;
    logic             w_grant_vld;
    logic [SEL_W-1:0] w_grant;
    logic [SEL_W-1:0] w_idx;
    logic [N_IN-1:0]  w_ready;
    logic             w_xfer;

    assign w_space = !r_out_valid || bus.out_ready;

    // Grant only ever points at a channel whose valid is high, so a grant
    // combined with space is by itself a transfer.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_idx       = '0;
        if (!bus.mode) begin
            if ((32'(bus.sel) < N_IN) && bus.in_valid[bus.sel]) begin
                w_grant_vld = 1'b1;
                w_grant     = bus.sel;
            end
        end else begin
            for (int k = 1; k <= N_IN; k++) begin
                w_idx = SEL_W'((32'(r_last) + 32'(k)) % N_IN);
                if (!w_grant_vld && bus.in_valid[w_idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = w_idx;
                end
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_grant_vld && w_space) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    assign w_xfer = w_grant_vld && w_space;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_last      <= c_last_init;
        end else if (w_xfer) begin
            r_out_data  <= bus.in_data[w_grant*WIDTH +: WIDTH];
            r_out_src   <= w_grant;
            r_out_valid <= 1'b1;
            if (bus.mode) begin
                r_last <= w_grant;
            end
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire
